// File: rtl/button_gesture_ctrl_if.sv
// Signal bundle between the button front end, the gesture classifier and its consumers.
// The master side drives the conditioned button signals; the slave side returns gesture pulses.
interface button_gesture_ctrl_if;
  logic en;
  logic level;
  logic p_edge;
  logic n_edge;
  logic short_press;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output en, level, p_edge, n_edge,
    input  short_press, double_click, long_press, repeat_pulse, busy
  );

  modport slave (
    input  en, level, p_edge, n_edge,
    output short_press, double_click, long_press, repeat_pulse, busy
  );
endinterface

// File: rtl/button_gesture_ctrl.sv
// Classifies debounced button presses into short press, double click, long press and auto-repeat.
// One FSM with a single shared timing counter; every gesture output is a registered one-cycle pulse.
module button_gesture_ctrl #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  button_gesture_ctrl_if.slave bus
);

  localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HELD
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_short_press;
  logic          r_double_click;
  logic          r_long_press;
  logic          r_repeat;

  // A coincident release masks a press, so only an isolated p_edge counts as a press.
  logic w_press;
  logic w_release;

  assign w_press   = bus.p_edge & ~bus.n_edge;
  assign w_release = bus.n_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_short_press  <= 1'b0;
      r_double_click <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat       <= 1'b0;
    end else begin
      r_short_press  <= 1'b0;
      r_double_click <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat       <= 1'b0;

      if (!bus.en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_press) begin
              r_state <= PRESS1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          PRESS1: begin
            if (w_release) begin
              r_state <= GAP;
              r_cnt   <= '0;
            end else if (r_cnt == LONG_LAST) begin
              r_state      <= HELD;
              r_cnt        <= '0;
              r_long_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          // A press landing on the expiry cycle still wins over the timeout.
          GAP: begin
            if (w_press) begin
              r_state <= PRESS2;
              r_cnt   <= '0;
            end else if (r_cnt == GAP_LAST) begin
              r_state       <= IDLE;
              r_cnt         <= '0;
              r_short_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          PRESS2: begin
            if (w_release) begin
              r_state        <= IDLE;
              r_cnt          <= '0;
              r_double_click <= 1'b1;
            end else if (r_cnt == LONG_LAST) begin
              r_state      <= HELD;
              r_cnt        <= '0;
              r_long_press <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          // The level check catches a release whose edge pulse was lost upstream.
          HELD: begin
            if (w_release || !bus.level) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == REPEAT_LAST) begin
              r_cnt    <= '0;
              r_repeat <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.short_press  = r_short_press;
  assign bus.double_click = r_double_click;
  assign bus.long_press   = r_long_press;
  assign bus.repeat_pulse = r_repeat;
  assign bus.busy         = (r_state != IDLE);

endmodule
